// File: rtl/adc_channel_sequencer_if.sv
// adc_channel_sequencer_if: ADC driver handshake and readout FIFO write port.
// master = sequencer side, slave = ADC driver / FIFO side.
interface adc_channel_sequencer_if;
    logic        AdcStart;
    logic [11:0] AdcData;
    logic        AdcOtr;
    logic        AdcData_en;
    logic [15:0] FifoData;
    logic        FifoWrEn;
    logic        FifoFull;

    modport master (
        output AdcStart,
        output FifoData,
        output FifoWrEn,
        input  AdcData,
        input  AdcOtr,
        input  AdcData_en,
        input  FifoFull
    );

    modport slave (
        input  AdcStart,
        input  FifoData,
        input  FifoWrEn,
        output AdcData,
        output AdcOtr,
        output AdcData_en,
        output FifoFull
    );
endinterface

// File: rtl/adc_channel_sequencer.sv
// adc_channel_sequencer: scans enabled mux channels, settles, runs the ADC
// for SamplesPerCh samples per channel and writes channel-tagged words.
// Ports: Clk, reset_n (async, active-low); Start/Abort run control;
// ChannelMask/SettleCycles/SamplesPerCh config; MuxSel mux select;
// Busy/Done/DropCount status; bus (master) = AdcStart, AdcData, AdcOtr,
// AdcData_en in/out of the ADC driver and FifoData/FifoWrEn/FifoFull.
module adc_channel_sequencer #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                   Clk,
    input  logic                   reset_n,
    input  logic                   Start,
    input  logic                   Abort,
    input  logic [NUM_CH-1:0]      ChannelMask,
    input  logic [7:0]             SettleCycles,
    input  logic [7:0]             SamplesPerCh,
    output logic [CH_W-1:0]        MuxSel,
    output logic                   Busy,
    output logic                   Done,
    output logic [7:0]             DropCount,
    adc_channel_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, SELECT, SETTLE, ACQUIRE, NEXT, FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [7:0]        settle_q, settle_d;
    logic [7:0]        spc_q, spc_d;
    logic [7:0]        settle_cnt_q, settle_cnt_d;
    logic [7:0]        sample_cnt_q, sample_cnt_d;
    logic [7:0]        sample_inc;
    logic              adc_start_q, adc_start_d;
    logic [CH_W-1:0]   mux_q, mux_d;
    logic [15:0]       data_q, data_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        drop_q, drop_d;
    logic [2:0]        ch3;

    // Index of the lowest set bit; pend only ever holds unscanned channels.
    function automatic logic [CH_W-1:0] lowest(
        input logic [NUM_CH-1:0] m
    );
        lowest = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest = CH_W'(i);
        end
    endfunction

    assign sample_inc = sample_cnt_q + 8'd1;
    assign ch3        = 3'(mux_q);

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        settle_d     = settle_q;
        spc_d        = spc_q;
        settle_cnt_d = settle_cnt_q;
        sample_cnt_d = sample_cnt_q;
        adc_start_d  = adc_start_q;
        mux_d        = mux_q;
        data_d       = data_q;
        wr_d         = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        drop_d       = drop_q;

        if (Abort) begin
            // Abort beats everything, including a Start in IDLE and a
            // sample being registered this cycle.
            state_d     = IDLE;
            adc_start_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        pend_d   = ChannelMask;
                        settle_d = SettleCycles;
                        spc_d    = SamplesPerCh;
                        busy_d   = 1'b1;
                        drop_d   = 8'd0;
                        if (ChannelMask == '0 || SamplesPerCh == 8'd0)
                            state_d = FINISH;
                        else
                            state_d = SELECT;
                    end
                end
                SELECT: begin
                    mux_d        = lowest(pend_q);
                    // clear the lowest set bit: channel now scanned
                    pend_d       = pend_q & (pend_q - 1'b1);
                    settle_cnt_d = 8'd0;
                    sample_cnt_d = 8'd0;
                    state_d      = SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt_q == settle_q) begin
                        adc_start_d = 1'b1;
                        state_d     = ACQUIRE;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 8'd1;
                    end
                end
                ACQUIRE: begin
                    if (bus.AdcData_en) begin
                        sample_cnt_d = sample_inc;
                        if (!bus.FifoFull) begin
                            wr_d   = 1'b1;
                            // ch[15:13], otr[12], sample[11:0]
                            data_d = {ch3, bus.AdcOtr, bus.AdcData};
                        end else if (drop_q != 8'hFF) begin
                            drop_d = drop_q + 8'd1;
                        end
                        if (sample_inc == spc_q) begin
                            adc_start_d = 1'b0;
                            state_d     = NEXT;
                        end
                    end
                end
                NEXT: begin
                    state_d = (pend_q != '0) ? SELECT : FINISH;
                end
                FINISH: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            settle_q     <= 8'd0;
            spc_q        <= 8'd0;
            settle_cnt_q <= 8'd0;
            sample_cnt_q <= 8'd0;
            adc_start_q  <= 1'b0;
            mux_q        <= '0;
            data_q       <= 16'd0;
            wr_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            settle_q     <= settle_d;
            spc_q        <= spc_d;
            settle_cnt_q <= settle_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            adc_start_q  <= adc_start_d;
            mux_q        <= mux_d;
            data_q       <= data_d;
            wr_q         <= wr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
        end
    end

    assign bus.AdcStart = adc_start_q;
    assign bus.FifoData = data_q;
    assign bus.FifoWrEn = wr_q;
    assign MuxSel       = mux_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign DropCount    = drop_q;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// tb_adc_channel_sequencer: random scans against a channel-list model;
// expected FIFO words are queued at stimulus time and popped by a monitor.
module tb_adc_channel_sequencer;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic              Clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              Start = 1'b0;
    logic              Abort = 1'b0;
    logic [NUM_CH-1:0] ChannelMask = '0;
    logic [7:0]        SettleCycles = 8'd0;
    logic [7:0]        SamplesPerCh = 8'd0;
    logic [CH_W-1:0]   MuxSel;
    logic              Busy;
    logic              Done;
    logic [7:0]        DropCount;

    adc_channel_sequencer_if bus ();

    adc_channel_sequencer #(
        .NUM_CH(NUM_CH),
        .CH_W  (CH_W)
    ) dut (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .Start       (Start),
        .Abort       (Abort),
        .ChannelMask (ChannelMask),
        .SettleCycles(SettleCycles),
        .SamplesPerCh(SamplesPerCh),
        .MuxSel      (MuxSel),
        .Busy        (Busy),
        .Done        (Done),
        .DropCount   (DropCount),
        .bus         (bus)
    );

    always #5 Clk = ~Clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_done = 0;
    int          exp_done = 0;
    logic [15:0] exp_q[$];

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: every FIFO write must match the oldest expected word.
    always @(posedge Clk) begin
        logic [15:0] e;
        #1;
        if (reset_n && Done) n_done++;
        if (reset_n && bus.FifoWrEn) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got %0h expected none",
                         bus.FifoData);
            end else begin
                e = exp_q.pop_front();
                check("fifo_data", bus.FifoData, e);
            end
        end
    end

    // full_mode: 0 never full, 1 random, 2 always, 3 full on samples 2 and 3
    task automatic run_scan(logic [NUM_CH-1:0] mask, logic [7:0] settle,
                            logic [7:0] spc, int full_mode,
                            int abort_ch, int abort_k, bit start_in_acq);
        int         chs[$];
        int         drops;
        int         lat;
        int         gap;
        logic [2:0] ch3;
        chs = {};
        for (int i = 0; i < NUM_CH; i++)
            if (mask[i]) chs.push_back(i);
        drops = 0;
        ChannelMask  = mask;
        SettleCycles = settle;
        SamplesPerCh = spc;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        ChannelMask  = NUM_CH'($urandom);
        SettleCycles = 8'($urandom);
        SamplesPerCh = 8'($urandom);
        check("busy_on_accept", Busy, 1);
        check("drop_cleared", DropCount, 0);
        if (chs.size() == 0 || spc == 8'd0) begin
            check("adcstart_empty", bus.AdcStart, 0);
            tick();
            check("done_empty", Done, 1);
            check("busy_empty", Busy, 0);
            tick();
            check("done_len_empty", Done, 0);
            exp_done++;
            return;
        end
        foreach (chs[c]) begin
            lat = 0;
            ch3 = 3'(chs[c]);
            while (!bus.AdcStart && lat < 600) begin
                // stray pulses land in SELECT/NEXT/SETTLE and are ignored
                if (lat <= int'(settle) && $urandom_range(2) == 0)
                    bus.AdcData_en = 1'b1;
                tick();
                bus.AdcData_en = 1'b0;
                lat++;
            end
            check("settle_latency", lat,
                  (c == 0) ? int'(settle) + 2 : int'(settle) + 3);
            if (!bus.AdcStart) return;
            check("muxsel", MuxSel, chs[c]);
            for (int k = 0; k < int'(spc); k++) begin
                gap = $urandom_range(3);
                for (int g = 0; g < gap; g++) begin
                    if (start_in_acq && g == 0) Start = 1'b1;
                    tick();
                    Start = 1'b0;
                end
                bus.AdcData    = 12'($urandom);
                bus.AdcOtr     = 1'($urandom);
                bus.AdcData_en = 1'b1;
                bus.FifoFull   = (full_mode == 2) ||
                    (full_mode == 1 && $urandom_range(2) == 0) ||
                    (full_mode == 3 && (k == 1 || k == 2));
                if (c == abort_ch && k == abort_k) begin
                    Abort = 1'b1;
                    tick();
                    Abort = 1'b0;
                    bus.AdcData_en = 1'b0;
                    bus.FifoFull   = 1'b0;
                    check("abort_adcstart", bus.AdcStart, 0);
                    check("abort_busy", Busy, 0);
                    check("abort_nowrite", bus.FifoWrEn, 0);
                    tick();
                    check("abort_no_done", Done, 0);
                    return;
                end
                if (bus.FifoFull)
                    drops++;
                else
                    exp_q.push_back({ch3, bus.AdcOtr, bus.AdcData});
                tick();
                bus.AdcData_en = 1'b0;
                bus.FifoFull   = 1'b0;
                check("adcstart_level", bus.AdcStart,
                      (k == int'(spc) - 1) ? 0 : 1);
            end
        end
        tick();
        tick();
        check("done", Done, 1);
        check("busy_end", Busy, 0);
        check("dropcount", DropCount, (drops > 255) ? 255 : drops);
        tick();
        check("done_len", Done, 0);
        exp_done++;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.AdcData    = 12'd0;
        bus.AdcOtr     = 1'b0;
        bus.AdcData_en = 1'b0;
        bus.FifoFull   = 1'b0;
        repeat (3) tick();
        check("rst_adcstart", bus.AdcStart, 0);
        check("rst_muxsel", MuxSel, 0);
        check("rst_fifodata", bus.FifoData, 0);
        check("rst_wren", bus.FifoWrEn, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_drop", DropCount, 0);
        reset_n = 1'b1;
        tick();

        run_scan(4'b0101, 8'd5, 8'd3, 0, -1, 0, 1'b0);
        run_scan(4'b0000, 8'd3, 8'd3, 0, -1, 0, 1'b0);
        run_scan(4'b0010, 8'd3, 8'd0, 0, -1, 0, 1'b0);
        run_scan(4'b0001, 8'd2, 8'd4, 3, -1, 0, 1'b0);
        run_scan(4'b1111, 8'd2, 8'd3, 0, 1, 1, 1'b0);
        run_scan(4'b1111, 8'd1, 8'd3, 0, -1, 0, 1'b0);
        run_scan(4'b1011, 8'd0, 8'd4, 0, -1, 0, 1'b1);
        run_scan(4'b1111, 8'd0, 8'd75, 2, -1, 0, 1'b0);
        run_scan(4'b1000, 8'd0, 8'd255, 1, -1, 0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            run_scan(4'($urandom), 8'($urandom_range(7)),
                     8'($urandom_range(6, 1)), $urandom_range(1),
                     -1, 0, 1'($urandom));
        end

        // Start together with Abort in IDLE is not accepted
        Start = 1'b1;
        Abort = 1'b1;
        ChannelMask = 4'b0001;
        SamplesPerCh = 8'd2;
        tick();
        Start = 1'b0;
        Abort = 1'b0;
        check("abort_start_busy", Busy, 0);
        tick();
        check("abort_start_done", Done, 0);

        // async reset mid-scan clears outputs without a clock edge
        ChannelMask  = 4'b0100;
        SettleCycles = 8'd20;
        SamplesPerCh = 8'd2;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        check("pre_reset_muxsel", MuxSel, 2);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_busy", Busy, 0);
        check("async_rst_muxsel", MuxSel, 0);
        check("async_rst_adcstart", bus.AdcStart, 0);
        tick();
        reset_n = 1'b1;
        tick();

        check("leftover_expected", exp_q.size(), 0);
        check("done_count", n_done, exp_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
